// File: rtl/acc_stack_unit.sv
// Accumulator with load/add/sub/clear, signed status flags, optional saturation
// and a LIFO save stack that preserves ACC across subroutine-style sequences.
module acc_stack_unit #(
    parameter int NBITS_D  = 16,
    parameter int DEPTH    = 4,
    parameter int SATURATE = 0
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_WrAcc,
    input  logic [1:0]                   i_op,
    input  logic [NBITS_D-1:0]           i_operand,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_clr_ovf,
    output logic [NBITS_D-1:0]           o_ACC,
    output logic                         o_zero,
    output logic                         o_neg,
    output logic                         o_ovf,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_ADD  = 2'b01,
        OP_SUB  = 2'b10,
        OP_CLR  = 2'b11
    } op_e;

    logic [NBITS_D-1:0] acc_q, acc_d;
    logic               ovf_q, ovf_d;
    logic               err_q, err_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NBITS_D-1:0] stack_q [DEPTH];

    logic               full, empty;
    logic               push_req, pop_req, do_push, do_pop, stack_err;
    logic [CW-1:0]      cnt_m1;
    logic [IW-1:0]      wr_idx, rd_idx;

    logic [NBITS_D:0]   ext_acc, ext_opd, arith;
    logic               arith_ovf;
    logic [NBITS_D-1:0] sat_val, arith_res;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

    // Simultaneous push and pop cancel each other and count as an illegal request.
    assign push_req  = i_push & ~i_pop;
    assign pop_req   = i_pop & ~i_push;
    assign do_push   = push_req & ~full;
    assign do_pop    = pop_req & ~empty;
    assign stack_err = (i_push & i_pop) | (push_req & full) | (pop_req & empty);

    assign cnt_m1 = cnt_q - CW'(1);
    assign wr_idx = cnt_q[IW-1:0];
    assign rd_idx = cnt_m1[IW-1:0];

    // Sign-extended by one bit: overflow shows as the top two bits disagreeing,
    // and the top bit gives the true sign for choosing the clamp value.
    assign ext_acc   = {acc_q[NBITS_D-1], acc_q};
    assign ext_opd   = {i_operand[NBITS_D-1], i_operand};
    assign arith     = (i_op == OP_SUB) ? (ext_acc - ext_opd) : (ext_acc + ext_opd);
    assign arith_ovf = arith[NBITS_D] ^ arith[NBITS_D-1];
    assign sat_val   = arith[NBITS_D] ? {1'b1, {(NBITS_D-1){1'b0}}}
                                      : {1'b0, {(NBITS_D-1){1'b1}}};
    assign arith_res = ((SATURATE != 0) && arith_ovf) ? sat_val : arith[NBITS_D-1:0];

    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q & ~i_clr_ovf;
        cnt_d = cnt_q;
        err_d = stack_err;
        if (do_pop) begin
            acc_d = stack_q[rd_idx];
            cnt_d = cnt_m1;
            ovf_d = ovf_q;
        end else begin
            if (do_push) begin
                cnt_d = cnt_q + CW'(1);
            end
            if (i_WrAcc) begin
                case (op_e'(i_op))
                    OP_LOAD: begin
                        acc_d = i_operand;
                        ovf_d = 1'b0;
                    end
                    OP_ADD, OP_SUB: begin
                        acc_d = arith_res;
                        if (arith_ovf) begin
                            ovf_d = 1'b1;
                        end
                    end
                    OP_CLR: begin
                        acc_d = '0;
                        ovf_d = 1'b0;
                    end
                    default: acc_d = acc_q;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end

    // Stack storage is not reset; the count alone defines which entries are live.
    always_ff @(posedge i_clk) begin
        if (!i_reset && do_push) begin
            stack_q[wr_idx] <= acc_q;
        end
    end

    assign o_ACC   = acc_q;
    assign o_zero  = (acc_q == '0);
    assign o_neg   = acc_q[NBITS_D-1];
    assign o_ovf   = ovf_q;
    assign o_full  = full;
    assign o_empty = empty;
    assign o_count = cnt_q;
    assign o_err   = err_q;

endmodule

// File: tb/tb_acc_stack_unit.sv
// Table-driven bench for acc_stack_unit: a wrapping and a saturating instance
// share one stimulus stream; expected values are hand-computed per row.
module tb_acc_stack_unit;

    localparam int N = 16;

    logic          clk = 1'b0;
    logic          rst, wr, push, pop, clr;
    logic [1:0]    op;
    logic [N-1:0]  opd;

    logic [N-1:0]  acc_w, acc_s;
    logic          zero_w, neg_w, ovf_w, full_w, empty_w, err_w;
    logic          zero_s, neg_s, ovf_s, full_s, empty_s, err_s;
    logic [2:0]    cnt_w, cnt_s;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    acc_stack_unit #(.NBITS_D(N), .DEPTH(4), .SATURATE(0)) u_wrap (
        .i_clk(clk), .i_reset(rst), .i_WrAcc(wr), .i_op(op), .i_operand(opd),
        .i_push(push), .i_pop(pop), .i_clr_ovf(clr),
        .o_ACC(acc_w), .o_zero(zero_w), .o_neg(neg_w), .o_ovf(ovf_w),
        .o_full(full_w), .o_empty(empty_w), .o_count(cnt_w), .o_err(err_w)
    );

    acc_stack_unit #(.NBITS_D(N), .DEPTH(4), .SATURATE(1)) u_sat (
        .i_clk(clk), .i_reset(rst), .i_WrAcc(wr), .i_op(op), .i_operand(opd),
        .i_push(push), .i_pop(pop), .i_clr_ovf(clr),
        .o_ACC(acc_s), .o_zero(zero_s), .o_neg(neg_s), .o_ovf(ovf_s),
        .o_full(full_s), .o_empty(empty_s), .o_count(cnt_s), .o_err(err_s)
    );

    typedef struct {
        logic         rst, wr;
        logic [1:0]   op;
        logic [N-1:0] opd;
        logic         push, pop, clr;
        logic [N-1:0] e_acc;
        logic         e_ovf;
        logic [2:0]   e_cnt;
        logic         e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic w, input logic [1:0] o,
                                input logic [N-1:0] d, input logic pu, input logic po,
                                input logic c, input logic [N-1:0] ea, input logic eo,
                                input logic [2:0] ec, input logic ee);
        vec_t v;
        v.rst = r; v.wr = w; v.op = o; v.opd = d; v.push = pu; v.pop = po; v.clr = c;
        v.e_acc = ea; v.e_ovf = eo; v.e_cnt = ec; v.e_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s row %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        rst = v.rst; wr = v.wr; op = v.op; opd = v.opd;
        push = v.push; pop = v.pop; clr = v.clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_wrap(input vec_t v, input int idx);
        chk("acc",   idx, 32'(acc_w),   32'(v.e_acc));
        chk("zero",  idx, 32'(zero_w),  32'(v.e_acc == '0));
        chk("neg",   idx, 32'(neg_w),   32'(v.e_acc[N-1]));
        chk("ovf",   idx, 32'(ovf_w),   32'(v.e_ovf));
        chk("count", idx, 32'(cnt_w),   32'(v.e_cnt));
        chk("full",  idx, 32'(full_w),  32'(v.e_cnt == 3'd4));
        chk("empty", idx, 32'(empty_w), 32'(v.e_cnt == 3'd0));
        chk("err",   idx, 32'(err_w),   32'(v.e_err));
    endtask

    initial begin
        rst = 1'b0; wr = 1'b0; op = 2'b00; opd = '0; push = 1'b0; pop = 1'b0; clr = 1'b0;

        //                 rst wr  op  operand  psh pop clr  e_acc    ovf cnt err
        vecs.push_back(mk(1, 0, 2'd0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'd0, 16'h1234, 0, 0, 0, 16'h1234, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'd1, 16'h0001, 0, 0, 0, 16'h1235, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'd0, 16'h7FFF, 0, 0, 0, 16'h7FFF, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'd1, 16'h0001, 0, 0, 0, 16'h8000, 1, 0, 0));
        vecs.push_back(mk(0, 1, 2'd0, 16'h0005, 0, 0, 0, 16'h0005, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'd2, 16'h0007, 0, 0, 0, 16'hFFFE, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'd1, 16'h8000, 0, 0, 0, 16'h7FFE, 1, 0, 0));
        vecs.push_back(mk(0, 0, 2'd0, 16'h0000, 0, 0, 1, 16'h7FFE, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'd2, 16'hFFFF, 0, 0, 0, 16'h7FFF, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'd2, 16'hFFFF, 0, 0, 1, 16'h8000, 1, 0, 0));
        vecs.push_back(mk(0, 1, 2'd3, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0));
        // save-then-modify and restore
        vecs.push_back(mk(0, 1, 2'd0, 16'h00AA, 0, 0, 0, 16'h00AA, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'd0, 16'h00BB, 1, 0, 0, 16'h00BB, 0, 1, 0));
        vecs.push_back(mk(0, 1, 2'd1, 16'h0005, 0, 1, 0, 16'h00AA, 0, 0, 0));
        // fill the stack, overflow push, then unwind
        vecs.push_back(mk(0, 1, 2'd0, 16'h0001, 1, 0, 0, 16'h0001, 0, 1, 0));
        vecs.push_back(mk(0, 1, 2'd0, 16'h0002, 1, 0, 0, 16'h0002, 0, 2, 0));
        vecs.push_back(mk(0, 1, 2'd0, 16'h0003, 1, 0, 0, 16'h0003, 0, 3, 0));
        vecs.push_back(mk(0, 1, 2'd0, 16'h0004, 1, 0, 0, 16'h0004, 0, 4, 0));
        vecs.push_back(mk(0, 1, 2'd0, 16'h0011, 1, 0, 0, 16'h0011, 0, 4, 1));
        vecs.push_back(mk(0, 0, 2'd0, 16'h0000, 0, 0, 0, 16'h0011, 0, 4, 0));
        vecs.push_back(mk(0, 0, 2'd0, 16'h0000, 0, 1, 0, 16'h0003, 0, 3, 0));
        vecs.push_back(mk(0, 0, 2'd0, 16'h0000, 0, 1, 0, 16'h0002, 0, 2, 0));
        vecs.push_back(mk(0, 0, 2'd0, 16'h0000, 0, 1, 0, 16'h0001, 0, 1, 0));
        vecs.push_back(mk(0, 0, 2'd0, 16'h0000, 0, 1, 0, 16'h00AA, 0, 0, 0));
        // empty pop and push+pop collisions
        vecs.push_back(mk(0, 1, 2'd0, 16'h0004, 0, 0, 0, 16'h0004, 0, 0, 0));
        vecs.push_back(mk(0, 1, 2'd1, 16'h0003, 0, 1, 0, 16'h0007, 0, 0, 1));
        vecs.push_back(mk(0, 0, 2'd0, 16'h0000, 1, 0, 0, 16'h0007, 0, 1, 0));
        vecs.push_back(mk(0, 1, 2'd0, 16'h0009, 1, 0, 0, 16'h0009, 0, 2, 0));
        vecs.push_back(mk(0, 1, 2'd1, 16'h0001, 1, 1, 0, 16'h000A, 0, 2, 1));
        // pop drops the op and leaves ovf alone
        vecs.push_back(mk(0, 1, 2'd0, 16'h7FFF, 0, 0, 0, 16'h7FFF, 0, 2, 0));
        vecs.push_back(mk(0, 1, 2'd1, 16'h0001, 0, 0, 0, 16'h8000, 1, 2, 0));
        vecs.push_back(mk(0, 1, 2'd3, 16'h0000, 0, 1, 0, 16'h0007, 1, 1, 0));
        // reset beats pop and op with count=3, ACC=0x0F0F, ovf=1
        vecs.push_back(mk(0, 1, 2'd0, 16'h8000, 1, 0, 0, 16'h8000, 0, 2, 0));
        vecs.push_back(mk(0, 1, 2'd1, 16'h8F0F, 1, 0, 0, 16'h0F0F, 1, 3, 0));
        vecs.push_back(mk(1, 1, 2'd1, 16'h0001, 0, 1, 0, 16'h0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 2'd0, 16'h0000, 0, 1, 0, 16'h0000, 0, 0, 1));
        vecs.push_back(mk(0, 0, 2'd0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i]);
            check_wrap(vecs[i], i);
        end

        // Saturation: both instances see the same stream, results diverge on overflow.
        drive(mk(1, 0, 2'd0, 16'h0000, 0, 0, 0, 16'h0, 0, 0, 0));
        chk("sat_reset_acc", 100, 32'(acc_s), 32'h0);
        drive(mk(0, 1, 2'd0, 16'h7FFF, 0, 0, 0, 16'h0, 0, 0, 0));
        drive(mk(0, 1, 2'd1, 16'h0001, 0, 0, 0, 16'h0, 0, 0, 0));
        chk("sat_pos_acc", 101, 32'(acc_s), 32'h7FFF);
        chk("sat_pos_ovf", 101, 32'(ovf_s), 32'h1);
        chk("sat_pos_neg", 101, 32'(neg_s), 32'h0);
        chk("wrap_pos_acc", 101, 32'(acc_w), 32'h8000);
        drive(mk(0, 1, 2'd0, 16'h8000, 0, 0, 0, 16'h0, 0, 0, 0));
        chk("sat_load_ovf", 102, 32'(ovf_s), 32'h0);
        drive(mk(0, 1, 2'd2, 16'h0002, 0, 0, 0, 16'h0, 0, 0, 0));
        chk("sat_neg_acc", 103, 32'(acc_s), 32'h8000);
        chk("sat_neg_ovf", 103, 32'(ovf_s), 32'h1);
        chk("wrap_neg_acc", 103, 32'(acc_w), 32'h7FFE);
        drive(mk(0, 1, 2'd0, 16'h0010, 0, 0, 0, 16'h0, 0, 0, 0));
        drive(mk(0, 1, 2'd2, 16'h0020, 0, 0, 0, 16'h0, 0, 0, 0));
        chk("sat_inrange_acc", 104, 32'(acc_s), 32'hFFF0);
        chk("sat_inrange_ovf", 104, 32'(ovf_s), 32'h0);
        chk("sat_inrange_zero", 104, 32'(zero_s), 32'h0);
        drive(mk(0, 1, 2'd1, 16'h8000, 0, 0, 0, 16'h0, 0, 0, 0));
        chk("sat_neg_add_acc", 105, 32'(acc_s), 32'h8000);
        chk("sat_neg_add_ovf", 105, 32'(ovf_s), 32'h1);
        chk("sat_count", 105, 32'(cnt_s), 32'h0);
        chk("sat_err", 105, 32'(err_s), 32'h0);
        chk("sat_empty", 105, 32'(empty_s), 32'h1);
        chk("sat_full", 105, 32'(full_s), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/acc_stack_unit.md
Name: acc_stack_unit

Overview:
Parametrised accumulator for the datapath. It extends the plain load-only accumulator with on-register arithmetic (load/add/sub/clear), signed status flags, optional saturation, and a LIFO save stack of configurable depth that preserves and restores ACC across subroutine-style sequences. It sits between the ALU/operand mux and the data-memory write path, and is driven by the control unit.

Parameters:
NBITS_D, 16, data width of ACC, operand and stack entries (>=2)
DEPTH, 4, number of stack entries (>=1)
SATURATE, 0, 0 = ADD/SUB wrap two's-complement; 1 = ADD/SUB clamp to signed max/min on overflow

Ports:
i_clk  input  1  clock; all state updates on the rising edge
i_reset  input  1  synchronous, active-high reset
i_WrAcc  input  1  enables the operation on i_op this cycle
i_op  input  2  00 LOAD, 01 ADD, 10 SUB, 11 CLR
i_operand  input  NBITS_D  operand for LOAD/ADD/SUB
i_push  input  1  push the current ACC onto the stack
i_pop  input  1  pop the top of stack into ACC
i_clr_ovf  input  1  clears the sticky overflow flag
o_ACC  output  NBITS_D  accumulator value
o_zero  output  1  ACC == 0
o_neg  output  1  ACC[NBITS_D-1]
o_ovf  output  1  sticky signed overflow
o_full  output  1  stack holds DEPTH entries
o_empty  output  1  stack holds 0 entries
o_count  output  clog2(DEPTH+1)  number of stack entries
o_err  output  1  one-cycle pulse on an illegal stack request

Behaviour:
- All outputs are registered or derived from registers. No combinational path from any input to any output.
- Clock and reset: the single clock is i_clk. i_reset is synchronous and active-high. On the edge where i_reset=1: ACC=0, o_ovf=0, count=0, o_err=0. Resulting outputs: o_zero=1, o_neg=0, o_empty=1, o_full=0. Reset overrides every other input on that edge. Stack storage contents need not be cleared.
- Latency: an operation presented at edge N is visible on o_ACC and the flags after edge N.
- Operations when i_WrAcc=1 and no pop occurs:
  - LOAD: ACC = i_operand.
  - ADD: ACC = ACC + i_operand.
  - SUB: ACC = ACC - i_operand.
  - CLR: ACC = 0.
- Operations when i_WrAcc=0: ACC holds.
- Overflow detection (ADD/SUB only): signed overflow occurs when the operand signs make the true result fall outside the signed range.
  - SATURATE=0: the result wraps.
  - SATURATE=1: the result clamps to 0111..1 (positive overflow) or 1000..0 (negative overflow).
  - In both modes o_ovf is set to 1 and stays set.
- o_ovf is cleared by i_clr_ovf, LOAD, or CLR. If overflow occurs in the same cycle as i_clr_ovf, the overflow wins and o_ovf=1.
- Push (i_push=1, i_pop=0, not full): stack[count] = ACC value *before* this edge; count+1. An operation requested in the same cycle still executes, so "save then modify" takes one cycle.
- Pop (i_pop=1, i_push=0, not empty): ACC = stack[count-1]; count-1. Pop has priority over i_WrAcc; the op is dropped and o_ovf is unchanged.
- Illegal stack requests: each one pulses o_err=1 for one cycle and leaves count and stack unchanged.
  - Push when full: the ACC operation proceeds normally.
  - Pop when empty: it is treated as no pop, so the ACC operation proceeds normally.
  - i_push=1 and i_pop=1 together: treated as neither, so the ACC operation proceeds normally.
- Otherwise o_err=0.
- Flags: o_zero and o_neg always reflect the current ACC. o_full = (count==DEPTH). o_empty = (count==0).
- Arithmetic width: operations are NBITS_D-bit modulo unless saturated. The internal sum/difference is computed at NBITS_D+1 bits or by the sign rule.

Test Plan:
1. Reset, then LOAD 0x1234, then ADD 0x0001 -> o_ACC=0x1235 after the second edge; o_zero=0, o_neg=0, o_ovf=0, o_empty=1.
2. SATURATE=0: LOAD 0x7FFF, then ADD 0x0001 -> o_ACC=0x8000, o_neg=1, o_ovf=1. A following LOAD 0x0005 -> o_ovf=0. With SATURATE=1 the same ADD gives o_ACC=0x7FFF, o_ovf=1; SUB 0x0002 from LOAD 0x8000 gives 0x8000, o_ovf=1.
3. LOAD 0x00AA; push together with LOAD 0x00BB -> o_ACC=0x00BB, o_count=1. Then pop -> o_ACC=0x00AA, o_count=0, o_empty=1.
4. DEPTH=4: push 4 times -> o_full=1, o_count=4. A 5th push together with LOAD 0x0011 -> o_err=1 for one cycle, o_count=4, o_ACC=0x0011. Four pops then return the values in reverse push order.
5. Pop when empty together with ADD 0x0003 from ACC=0x0004 -> o_err=1, o_ACC=0x0007. Simultaneous push+pop with count=2 -> o_err=1, o_count=2.
6. With o_count=3, ACC=0x0F0F, o_ovf=1, assert i_reset together with i_pop=1 and i_WrAcc=1 -> after the edge o_ACC=0, o_count=0, o_ovf=0, o_zero=1, o_err=0.
